preset_writer: RTL
==================

Name: preset_writer

Overview:
- Initiator side of the per-digit write interface used by the 4-digit up/down counter (digit select, 4-bit value, active-low write enable).
- Accepts a whole 4-digit BCD preset through a valid/ready handshake and replays it as a timed sequence of single-digit writes, least significant digit first.
- Sits between the user/command logic and the counter's digit write port. Validates BCD content and supports per-digit masking and abort.

Parameters:
- HOLD_CYCLES, 2, number of cycles wenable_o is held low per digit write (legal range 1..15).
- CHECK_BCD, 1, when 1, a preset containing any selected nibble >9 is rejected; when 0, nibbles are forwarded unchecked.

Ports:
- ck_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active high.
- load_i  input  1  preset request valid.
- ready_o  output  1  block idle and able to accept load_i.
- preset_i  input  16  BCD preset; [3:0]=digit 0 ... [15:12]=digit 3.
- mask_i  input  4  digit write mask; bit n=1 writes digit n.
- abort_i  input  1  synchronous abort of an in-progress sequence.
- digit_o  output  2  digit select to the counter write port.
- wvalue_o  output  4  value for the selected digit.
- wenable_o  output  1  write strobe, active low.
- busy_o  output  1  sequence in progress.
- done_o  output  1  one-cycle pulse when a sequence completes.
- err_o  output  1  one-cycle pulse when a preset is rejected.

Behaviour:
- Reset (async, immediate): state IDLE; ready_o=1, wenable_o=1, digit_o=0, wvalue_o=0, busy_o=0, done_o=0, err_o=0; internal preset/mask registers cleared.
- Handshake: a request is accepted on a rising edge where load_i=1 and ready_o=1. preset_i and mask_i are registered at acceptance; later input changes have no effect. ready_o=1 only in IDLE.
- Validation at acceptance: if CHECK_BCD=1 and any nibble with its mask bit set is >9, err_o=1 for the next cycle, state stays IDLE, and no write occurs. Unmasked nibbles are never checked.
- If mask_i=0 and the preset is valid, done_o pulses in the next cycle and no write occurs.
- FSM states: IDLE -> SETUP -> STROBE -> RELEASE -> (SETUP for the next masked digit | DONE) -> IDLE.
- SETUP (1 cycle): digit_o=idx, wvalue_o=nibble[idx], wenable_o=1. Address and data are stable before the strobe.
- STROBE (HOLD_CYCLES cycles): wenable_o=0; digit_o and wvalue_o unchanged.
- RELEASE (1 cycle): wenable_o=1; digit_o and wvalue_o still unchanged.
- DONE (1 cycle): done_o=1, busy_o=0. The next cycle is IDLE with ready_o=1.
- Digit order: ascending index; digits with mask bit 0 are skipped with no cycles spent on them.
- busy_o=1 in SETUP, STROBE and RELEASE.
- Timing: for k masked digits, the sequence occupies k*(HOLD_CYCLES+2) cycles, then DONE.
- Example, HOLD_CYCLES=2, all 4 digits: accept at edge 0; cycles 1..16 carry the writes; done_o in cycle 17; ready_o in cycle 18.
- Abort: abort_i=1 in any busy state moves to IDLE on the next edge. wenable_o returns to 1 that edge, done_o is not asserted, and already-written digits are not undone. abort_i is ignored in IDLE and DONE.
- load_i while busy is ignored; it is not queued.
- wenable_o is registered (glitch-free); at most one digit is written per strobe.
- HOLD_CYCLES counter: 4 bits, reloaded on entry to STROBE.

Test Plan:
- Reset mid-STROBE (wenable_o=0): assert rst_i between edges -> wenable_o=1, ready_o=1, busy_o=0 immediately, without waiting for a clock edge.
- preset_i=16'h1234, mask_i=4'hF, HOLD_CYCLES=2 -> four writes (digit 0/value 4, 1/3, 2/2, 3/1), each with wenable_o low for exactly 2 cycles; done_o in cycle 17; ready_o in cycle 18.
- preset_i=16'h9A05, mask_i=4'b1011 (digit 2 = A, but unmasked) -> writes digit 0=5, digit 1=0, digit 3=9 only; done_o in cycle 13; err_o stays 0.
- preset_i=16'h00B0, mask_i=4'hF, CHECK_BCD=1 -> err_o high for 1 cycle, no wenable_o low, ready_o remains 1.
- abort_i pulsed during digit 1 STROBE -> wenable_o=1 on next edge, IDLE, no done_o; a new load is then accepted normally.
- load_i held high for the whole sequence with a changing preset_i -> only the first preset is written; the second accept occurs only when ready_o=1 in cycle 18.

Source files
------------

// File: rtl/preset_writer.sv
`default_nettype none
// ============================================================================
// preset_writer : replays an accepted 4-digit BCD preset as a sequence of
//                 single-digit writes (LSD first) to the counter write port.
// Revision 1.0
// ============================================================================
module preset_writer #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter bit          CHECK_BCD   = 1'b1
) (
    input  logic        ck_i,
    input  logic        rst_i,
    input  logic        load_i,
    output logic        ready_o,
    input  logic [15:0] preset_i,
    input  logic [3:0]  mask_i,
    input  logic        abort_i,
    output logic [1:0]  digit_o,
    output logic [3:0]  wvalue_o,
    output logic        wenable_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] STROBE  = 3'd2;
    localparam logic [2:0] RELEASE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

    logic [2:0]  state_q,  state_d;
    logic [15:0] preset_q, preset_d;
    logic [3:0]  pend_q,   pend_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [1:0]  digit_q,  digit_d;
    logic [3:0]  wvalue_q, wvalue_d;
    logic        wen_q,    wen_d;
    logic        err_q,    err_d;

    logic [3:0]  w_bad;
    logic        w_reject;
    logic        w_busy;
    logic [3:0]  w_src_mask;
    logic [15:0] w_src_preset;
    logic        w_found;
    logic [1:0]  w_first;
    logic [3:0]  w_nibble;
    logic [3:0]  w_first_bit;

    // Only digits that will actually be written take part in BCD validation.
    generate
        for (genvar n = 0; n < 4; n++) begin : g_digit
            assign w_bad[n] = mask_i[n] && (preset_i[4*n +: 4] > 4'd9);
        end
    endgenerate

    assign w_reject = (CHECK_BCD != 1'b0) && (|w_bad);
    assign w_busy   = (state_q == SETUP) || (state_q == STROBE) || (state_q == RELEASE);

    // In IDLE the first digit is picked straight from the request inputs so
    // that SETUP can follow acceptance without an extra cycle.
    assign w_src_mask   = (state_q == IDLE) ? mask_i   : pend_q;
    assign w_src_preset = (state_q == IDLE) ? preset_i : preset_q;

    always_comb begin
        w_found = 1'b0;
        w_first = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (w_src_mask[n]) begin
                w_found = 1'b1;
                w_first = 2'(n);
            end
        end
    end

    assign w_nibble    = w_src_preset[{w_first, 2'b00} +: 4];
    assign w_first_bit = 4'b0001 << w_first;

    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        wvalue_d = wvalue_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    if (w_reject) begin
                        err_d = 1'b1;
                    end else begin
                        preset_d = preset_i;
                        if (w_found) begin
                            state_d  = SETUP;
                            digit_d  = w_first;
                            wvalue_d = w_nibble;
                            pend_d   = mask_i & ~w_first_bit;
                        end else begin
                            state_d = DONE;
                            pend_d  = 4'd0;
                        end
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = HOLD_RELOAD;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELEASE: begin
                if (w_found) begin
                    state_d  = SETUP;
                    digit_d  = w_first;
                    wvalue_d = w_nibble;
                    pend_d   = pend_q & ~w_first_bit;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort keeps the bus values; only the strobe and sequencing stop.
        if (abort_i && w_busy) begin
            state_d  = IDLE;
            pend_d   = 4'd0;
            digit_d  = digit_q;
            wvalue_d = wvalue_q;
        end
    end

    assign wen_d = (state_d != STROBE);

    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            preset_q <= 16'd0;
            pend_q   <= 4'd0;
            cnt_q    <= 4'd0;
            digit_q  <= 2'd0;
            wvalue_q <= 4'd0;
            wen_q    <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            wvalue_q <= wvalue_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign busy_o    = w_busy;
    assign done_o    = (state_q == DONE);
    assign err_o     = err_q;
    assign wenable_o = wen_q;
    assign digit_o   = digit_q;
    assign wvalue_o  = wvalue_q;

endmodule
`default_nettype wire
